// File: rtl/cc_cond_unit_pkg.sv
// y86_cc_pkg: flag indices, CC reset value, condition codes and FSM states for cc_cond_unit
package y86_cc_pkg;
  localparam int ZF_IDX = 0;
  localparam int SF_IDX = 1;
  localparam int OF_IDX = 2;
  localparam logic [2:0] CC_RESET = 3'b001;
  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/cc_cond_unit_if.sv
// cc_cond_unit_if: ALU flag delivery and condition query/response signals
interface cc_cond_unit_if;
  logic       alu_start;
  logic       alu_start_ready;
  logic       alu_done;
  logic       alu_cc_en;
  logic [2:0] alu_cf;
  logic       cond_req;
  logic [3:0] cond_ifun;
  logic       cond_ready;
  logic       cnd_valid;
  logic       cnd;
  logic       cond_err;
  logic [2:0] cc;
  modport slave (
    input  alu_start, alu_done, alu_cc_en, alu_cf, cond_req, cond_ifun,
    output alu_start_ready, cond_ready, cnd_valid, cnd, cond_err, cc
  );
  modport master (
    output alu_start, alu_done, alu_cc_en, alu_cf, cond_req, cond_ifun,
    input  alu_start_ready, cond_ready, cnd_valid, cnd, cond_err, cc
  );
endinterface

// File: rtl/cc_cond_unit_cond_eval.sv
// cond_eval: combinational Y86 jXX/cmovXX condition decode from {OF,SF,ZF}
module cond_eval
  import y86_cc_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic [2:0] flags,
  output logic       cnd,
  output logic       err
);
  logic lt, zf;
  always_comb begin
    lt  = flags[SF_IDX] ^ flags[OF_IDX];
    zf  = flags[ZF_IDX];
    err = ifun > C_G;
    cnd = ifun == C_ALWAYS ? 1'b1 :
          ifun == C_LE     ? lt | zf :
          ifun == C_L      ? lt :
          ifun == C_E      ? zf :
          ifun == C_NE     ? ~zf :
          ifun == C_GE     ? ~lt :
          ifun == C_G      ? ~lt & ~zf : 1'b0;
  end
endmodule

// File: rtl/cc_cond_unit.sv
// cc_cond_unit: CC register plus condition evaluator that holds queries until older ALU ops deliver flags
module cc_cond_unit
  import y86_cc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 3
) (
  input logic           clk,
  input logic           reset,
  cc_cond_unit_if.slave bus
);
  state_t     state_q, state_d;
  logic [1:0] out_q, out_d, wait_q, wait_d, wait_now;
  logic [3:0] ifun_q, ifun_d, eval_ifun;
  logic [2:0] cc_q, cc_d;
  logic       cnd_valid_q, cnd_valid_d, cnd_q, cnd_d, err_q, err_d;
  logic       done_v, start_v, fire, eval_cnd, eval_err;
  assign bus.alu_start_ready = out_q < 2'(MAX_OUTSTANDING);
  assign bus.cond_ready      = state_q == S_IDLE;
  assign bus.cnd_valid       = cnd_valid_q;
  assign bus.cnd             = cnd_q;
  assign bus.cond_err        = err_q;
  assign bus.cc              = cc_q;
  // cc_d doubles as the bypassed flags so a same-cycle done is seen by the evaluation
  always_comb begin
    done_v      = bus.alu_done && out_q != 2'd0;
    start_v     = bus.alu_start && bus.alu_start_ready;
    out_d       = out_q + 2'(start_v) - 2'(done_v);
    cc_d        = (done_v && bus.alu_cc_en) ? bus.alu_cf : cc_q;
    wait_now    = (state_q == S_IDLE ? out_q : wait_q) - 2'(done_v);
    wait_d      = wait_now;
    eval_ifun   = state_q == S_IDLE ? bus.cond_ifun : ifun_q;
    ifun_d      = eval_ifun;
    fire        = ((state_q == S_IDLE && bus.cond_req) || (state_q == S_WAIT && done_v)) && wait_now == 2'd0;
    state_d     = fire ? S_RESP :
                  (state_q == S_IDLE && bus.cond_req) ? S_WAIT :
                  state_q == S_RESP ? S_IDLE : state_q;
    cnd_valid_d = fire;
    cnd_d       = fire & eval_cnd;
    err_d       = fire & eval_err;
  end
  cond_eval u_eval (
    .ifun  (eval_ifun),
    .flags (cc_d),
    .cnd   (eval_cnd),
    .err   (eval_err)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      wait_q      <= '0;
      ifun_q      <= '0;
      cc_q        <= CC_RESET;
      cnd_valid_q <= 1'b0;
      cnd_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      wait_q      <= wait_d;
      ifun_q      <= ifun_d;
      cc_q        <= cc_d;
      cnd_valid_q <= cnd_valid_d;
      cnd_q       <= cnd_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_cc_cond_unit.sv
// tb_cc_cond_unit: directed plus random stimulus against a cycle-level reference model
module tb_cc_cond_unit;
  logic clk = 1'b0;
  logic reset;
  cc_cond_unit_if bus ();
  cc_cond_unit #(.MAX_OUTSTANDING(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_err = 0;
  int m_out, m_left;
  bit [2:0] m_cc;
  bit [3:0] m_ifun;
  bit m_busy, m_resp, m_cnd, m_err;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit ref_cnd(bit [3:0] f, bit [2:0] c);
    bit zf = c[0];
    bit lt = c[1] != c[2];
    case (f)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction
  task automatic step(input bit rs, input bit st, input bit dn, input bit en,
                      input bit [2:0] cf, input bit rq, input bit [3:0] fn);
    bit dok, sok, nr;
    bit [2:0] ccn;
    reset = rs;
    bus.alu_start = st;
    bus.alu_done = dn;
    bus.alu_cc_en = en;
    bus.alu_cf = cf;
    bus.cond_req = rq;
    bus.cond_ifun = fn;
    if (rs) begin
      m_out = 0; m_cc = 3'b001; m_busy = 0; m_resp = 0; m_cnd = 0; m_err = 0; m_left = 0;
    end else begin
      dok = dn && m_out > 0;
      sok = st && m_out < 3;
      ccn = (dok && en) ? cf : m_cc;
      nr = 0;
      if (!m_busy && !m_resp && rq) begin
        m_left = m_out - int'(dok);
        m_ifun = fn;
        if (m_left == 0) nr = 1;
        else m_busy = 1;
      end else if (m_busy && dok) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          nr = 1;
        end
      end
      if (nr) begin
        m_cnd = ref_cnd(m_ifun, ccn);
        m_err = m_ifun > 4'd6;
      end
      m_out = m_out + int'(sok) - int'(dok);
      m_cc = ccn;
      m_resp = nr;
    end
    @(posedge clk);
    #1;
    chk("cc", bus.cc, m_cc);
    chk("cnd_valid", bus.cnd_valid, m_resp);
    chk("cond_ready", bus.cond_ready, !m_busy && !m_resp);
    chk("start_ready", bus.alu_start_ready, m_out < 3);
    if (m_resp) begin
      chk("cnd", bus.cnd, m_cnd);
      chk("cond_err", bus.cond_err, m_err);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 3'b000, 0, 4'd0);
  endtask
  initial begin
    step(1, 0, 0, 0, 3'b000, 0, 4'd0);
    step(1, 0, 0, 0, 3'b000, 0, 4'd0);
    chk("rst_cc", bus.cc, 3'b001);
    chk("rst_ready", bus.cond_ready, 1'b1);
    chk("rst_valid", bus.cnd_valid, 1'b0);
    step(0, 0, 0, 0, 3'b000, 1, 4'd3);
    chk("e_valid", bus.cnd_valid, 1'b1);
    chk("e_cnd", bus.cnd, 1'b1);
    idle(1);
    step(0, 1, 0, 0, 3'b000, 0, 4'd0);
    step(0, 0, 0, 0, 3'b000, 1, 4'd2);
    chk("l_wait", bus.cnd_valid, 1'b0);
    step(0, 0, 1, 1, 3'b010, 0, 4'd0);
    chk("l_valid", bus.cnd_valid, 1'b1);
    chk("l_cnd", bus.cnd, 1'b1);
    chk("l_cc", bus.cc, 3'b010);
    idle(1);
    for (int r = 0; r < 2; r++) begin
      step(0, 1, 0, 0, 3'b000, 0, 4'd0);
      step(0, 1, 0, 0, 3'b000, 0, 4'd0);
      step(0, 0, 0, 0, 3'b000, 1, r == 0 ? 4'd5 : 4'd1);
      step(0, 0, 1, 1, 3'b001, 0, 4'd0);
      chk("two_wait", bus.cnd_valid, 1'b0);
      step(0, 0, 1, 1, 3'b100, 0, 4'd0);
      chk("two_valid", bus.cnd_valid, 1'b1);
      chk("two_cnd", bus.cnd, r == 0 ? 1'b0 : 1'b1);
      idle(1);
    end
    step(0, 1, 0, 0, 3'b000, 0, 4'd0);
    step(0, 1, 1, 1, 3'b001, 1, 4'd4);
    chk("ne_valid", bus.cnd_valid, 1'b1);
    chk("ne_cnd", bus.cnd, 1'b0);
    step(0, 0, 1, 0, 3'b000, 0, 4'd0);
    idle(1);
    step(0, 0, 0, 0, 3'b000, 1, 4'd9);
    chk("bad_err", bus.cond_err, 1'b1);
    chk("bad_cnd", bus.cnd, 1'b0);
    idle(1);
    step(0, 1, 0, 0, 3'b000, 0, 4'd0);
    step(0, 0, 1, 1, 3'b110, 0, 4'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 3'b000, 0, 4'd0);
    chk("full_ready", bus.alu_start_ready, 1'b0);
    step(0, 0, 0, 0, 3'b000, 1, 4'd3);
    chk("full_wait", bus.cond_ready, 1'b0);
    step(1, 0, 0, 0, 3'b000, 0, 4'd0);
    chk("rstw_valid", bus.cnd_valid, 1'b0);
    chk("rstw_cc", bus.cc, 3'b001);
    idle(3);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0 ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6)));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
